fp_addsub_pipe: RTL and testbench
=================================

// Module: fp_addsub_pipe
// PURPOSE
//  Parametrised, 3-stage pipelined IEEE-754-style floating-point add/subtract unit; successor to the single-format ALU add path.
//  Generic exponent/mantissa widths, 4 rounding modes, full valid/ready backpressure, one result per cycle.
//  Sits between the operand issue logic and result writeback; flags feed the FP status register.
// PARAMETERS
//  EXP_W  8   exponent field width (>=3)
//  MAN_W  23  stored mantissa field width (>=2); W = 1+EXP_W+MAN_W
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   synchronous reset, active-high
//  op_a       in   W   operand A {sign, exp, man}
//  op_b       in   W   operand B
//  op_sub     in   1   1: A-B, 0: A+B
//  round_mode in   2   00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf)
//  start      in   1   input valid
//  ready_out  out  1   unit can accept; transfer when start&&ready_out
//  valid_out  out  1   result valid
//  ready_in   in   1   downstream ready; result consumed when valid_out&&ready_in
//  result     out  W   packed result
//  flags      out  5   {invalid, divzero(=0), overflow, underflow, inexact}
// BEHAVIOUR
//  - Reset: all stage valids, valid_out, result, flags clear to 0; in-flight ops discarded, no output.
//  - Stages: S1 unpack/classify/swap by magnitude/align (shift saturates, shifted-out bits OR into sticky);
//    S2 signed mantissa add, leading-zero count, normalise; S3 round, exponent adjust, pack, flags.
//  - Latency 3 cycles start->valid_out with ready_in=1; throughput 1/cycle.
//  - Global advance en = !valid_out || ready_in; ready_out = en (combinational); all stages hold when !en.
//  - Bubbles propagate as cleared valids; order strictly preserved; no op lost or duplicated under stall.
//  - Operand B sign inverted when op_sub=1 before classification.
//  - Subnormal inputs treated as same-signed zero (DAZ); tiny results flushed to signed zero, underflow+inexact.
//  - Rounding: guard/round/sticky; RNE ties to even; RUP/RDN round magnitude up iff inexact and sign matches direction.
//  - Mantissa carry-out on rounding increments exponent; exp reaching all-ones -> overflow.
//  - Overflow: RNE -> inf; RTZ -> max finite; RUP -> +inf / -max finite; RDN -> -inf / +max finite;
//    flags overflow+inexact.
//  - NaN in either operand -> canonical qNaN {0, all-ones, 1, 0...}; invalid only if an input is sNaN.
//  - inf + (-inf) (effective) -> canonical qNaN, invalid. inf +/- finite -> that inf, no flags.
//  - Exact zero sum of opposite-signed operands -> +0, except RDN -> -0; (-0)+(-0) -> -0, (+0)+(+0) -> +0.
//  - flags valid only with valid_out; divzero bit is constant 0.
// CONFIGURATION
//  FP_ADDSUB_STICKY_FLAGS_EN defined: extra port flags_acc out 5 and input flags_clr in 1; flags_acc ORs flags
//    of every consumed result; flags_clr clears it (clear wins over same-cycle set); reset -> 0.
//  Undefined: ports absent, no accumulator logic; all other behaviour identical.
// TESTING  (EXP_W=8, MAN_W=23, RNE unless stated)
//  41A60000 + 40100000 -> 41B80000, flags 00000, valid_out exactly 3 cycles after accept.
//  42293333 - 418828F6 -> 41CA3D70, flags 00000; 3F800000 + 33800000 -> 3F800000, inexact (tie to even).
//  7F7FFFFF + 7F7FFFFF -> 7F800000 flags 00101; same with RTZ -> 7F7FFFFF flags 00101.
//  7F800000 - 7F800000 -> 7FC00000 flags 10000; 40A80000 - 40A80000 -> 00000000, with RDN -> 80000000.
//  Back-to-back 6 ops, ready_in held low 5 cycles mid-stream -> ready_out low while stalled, all 6 results in order, none lost.
//  rst pulsed 1 cycle with 2 ops in flight -> no valid_out for them; next op completes normally in 3 cycles.

Source files
------------

// File: rtl/fp_addsub_pipe_if.sv
// Operand/result bundle for fp_addsub_pipe. The master side issues operands and consumes results.
// An operand transfers when start && ready_out; a result transfers when valid_out && ready_in.
interface fp_addsub_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sub;
    logic [1:0]   round_mode;
    logic         start;
    logic         ready_out;
    logic         valid_out;
    logic         ready_in;
    logic [W-1:0] result;
    logic [4:0]   flags;

    modport master (
        output op_a, op_b, op_sub, round_mode, start, ready_in,
        input  ready_out, valid_out, result, flags
    );

    modport slave (
        input  op_a, op_b, op_sub, round_mode, start, ready_in,
        output ready_out, valid_out, result, flags
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// 3-stage floating-point add/subtract: S1 classify/swap/align, S2 add/normalise, S3 round/pack.
// Optional flag accumulator (flags_acc/flags_clr) when FP_ADDSUB_STICKY_FLAGS_EN is defined.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic clk,
    input  logic rst,
    fp_addsub_pipe_if.slave bus
`ifdef FP_ADDSUB_STICKY_FLAGS_EN
    ,
    input  logic       flags_clr,
    output logic [4:0] flags_acc
`endif
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int FW  = MAN_W + 4;
    localparam int FRW = MAN_W + 1;
    localparam int LZW = $clog2(FW);
    localparam int XW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

    // mx/my/nm layout: {hidden, fraction, guard, round, sticky}
    typedef struct packed {
        logic             valid;
        logic             special;
        logic [W-1:0]     spec_res;
        logic [4:0]       spec_flags;
        logic             sign;
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [FW-1:0]    mx;
        logic [FW-1:0]    my;
        logic [1:0]       rm;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic             special;
        logic [W-1:0]     spec_res;
        logic [4:0]       spec_flags;
        logic             sign;
        logic [XW-1:0]    exp;
        logic [FW-1:0]    nm;
        logic [1:0]       rm;
    } s2_t;

    s1_t s1_q, s1_d, s1_n;
    s2_t s2_q, s2_d, s2_n;
    logic [W-1:0] result_q, result_d, result_n;
    logic [4:0]   flags_q, flags_d, flags_n;
    logic         valid_out_q, valid_out_d;
    logic         en;

    assign en            = !valid_out_q || bus.ready_in;
    assign bus.ready_out = en;
    assign bus.valid_out = valid_out_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    // S1 signals
    logic [W-1:0]     a, b;
    logic [EXP_W-1:0] a_exp, b_exp, x_exp, y_exp, shift;
    logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, swap, sticky;
    logic [W-2:0]     a_mag, b_mag, x_mag, y_mag;
    logic [FW-1:0]    y_ext, y_al;

    always_comb begin
        a     = bus.op_a;
        b     = {bus.op_b[W-1] ^ bus.op_sub, bus.op_b[W-2:0]};
        a_exp = a[W-2:MAN_W];
        b_exp = b[W-2:MAN_W];
        a_nan  = (a_exp == EXP_MAX) && (a[MAN_W-1:0] != '0);
        b_nan  = (b_exp == EXP_MAX) && (b[MAN_W-1:0] != '0);
        a_snan = a_nan && !a[MAN_W-1];
        b_snan = b_nan && !b[MAN_W-1];
        a_inf  = (a_exp == EXP_MAX) && (a[MAN_W-1:0] == '0);
        b_inf  = (b_exp == EXP_MAX) && (b[MAN_W-1:0] == '0);
        // Subnormals collapse to zero magnitude before the compare
        a_mag = (a_exp == '0) ? '0 : a[W-2:0];
        b_mag = (b_exp == '0) ? '0 : b[W-2:0];
        swap  = b_mag > a_mag;
        x_mag = swap ? b_mag : a_mag;
        y_mag = swap ? a_mag : b_mag;
        x_exp = x_mag[W-2:MAN_W];
        y_exp = y_mag[W-2:MAN_W];
        shift = x_exp - y_exp;
        y_ext = {|y_exp, y_mag[MAN_W-1:0], 3'b000};
        if (32'(shift) >= FW) begin
            y_al   = '0;
            sticky = |y_ext;
        end else begin
            y_al   = y_ext >> shift;
            sticky = |(y_ext & ((FW'(1) << shift) - FW'(1)));
        end

        s1_n.valid      = bus.start;
        s1_n.sign       = swap ? b[W-1] : a[W-1];
        s1_n.eff_sub    = a[W-1] ^ b[W-1];
        s1_n.exp        = x_exp;
        s1_n.mx         = {|x_exp, x_mag[MAN_W-1:0], 3'b000};
        s1_n.my         = y_al | FW'(sticky);
        s1_n.rm         = bus.round_mode;
        s1_n.special    = 1'b1;
        s1_n.spec_res   = QNAN;
        s1_n.spec_flags = '0;
        if (a_nan || b_nan) begin
            s1_n.spec_flags = {a_snan || b_snan, 4'b0000};
        end else if (a_inf && b_inf && (a[W-1] != b[W-1])) begin
            s1_n.spec_flags = 5'b10000;
        end else if (a_inf) begin
            s1_n.spec_res = {a[W-1], EXP_MAX, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            s1_n.spec_res = {b[W-1], EXP_MAX, {MAN_W{1'b0}}};
        end else begin
            s1_n.special  = 1'b0;
            s1_n.spec_res = '0;
        end

        s1_d = s1_q;
        if (en) s1_d = s1_n;
    end

    // S2 signals
    logic [FW:0]   sum;
    logic [XW-1:0] lz, e1;

    always_comb begin
        sum = s1_q.eff_sub ? ({1'b0, s1_q.mx} - {1'b0, s1_q.my})
                           : ({1'b0, s1_q.mx} + {1'b0, s1_q.my});
        e1  = XW'(s1_q.exp);
        lz  = '0;
        for (int i = 0; i < FW; i++) begin
            if (sum[i]) lz = XW'(FW - 1 - i);
        end

        s2_n.valid      = s1_q.valid;
        s2_n.special    = s1_q.special;
        s2_n.spec_res   = s1_q.spec_res;
        s2_n.spec_flags = s1_q.spec_flags;
        s2_n.rm         = s1_q.rm;
        s2_n.sign       = s1_q.sign;
        if (sum[FW]) begin
            s2_n.nm  = sum[FW:1] | FW'(sum[0]);
            s2_n.exp = e1 + XW'(1);
        end else begin
            s2_n.nm  = sum[FW-1:0] << lz;
            s2_n.exp = e1 - lz;
        end
        // Exact cancellation: sign depends only on rounding direction
        if (sum == '0 && s1_q.eff_sub) s2_n.sign = (s1_q.rm == 2'b11);

        s2_d = s2_q;
        if (en) s2_d = s2_n;
    end

    // S3 signals
    logic             tiny, zero, ovf, inexact, inc, to_inf;
    logic [FRW-1:0]   frac_r;
    logic [XW-1:0]    exp_r;

    always_comb begin
        zero    = !s2_q.nm[FW-1];
        tiny    = s2_q.exp[XW-1] || (s2_q.exp == '0);
        inexact = |s2_q.nm[2:0];
        case (s2_q.rm)
            2'b00:   inc = s2_q.nm[2] && (s2_q.nm[1] || s2_q.nm[0] || s2_q.nm[3]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = inexact && !s2_q.sign;
            default: inc = inexact && s2_q.sign;
        endcase
        frac_r = {1'b0, s2_q.nm[FW-2:3]} + FRW'(inc);
        exp_r  = s2_q.exp + XW'(frac_r[MAN_W]);
        ovf    = exp_r >= XW'(EXP_MAX);
        to_inf = (s2_q.rm == 2'b00) || (s2_q.rm == 2'b10 && !s2_q.sign) ||
                 (s2_q.rm == 2'b11 && s2_q.sign);

        if (s2_q.special) begin
            result_n = s2_q.spec_res;
            flags_n  = s2_q.spec_flags;
        end else if (zero) begin
            result_n = {s2_q.sign, {(W-1){1'b0}}};
            flags_n  = 5'b00000;
        end else if (tiny) begin
            result_n = {s2_q.sign, {(W-1){1'b0}}};
            flags_n  = 5'b00011;
        end else if (ovf) begin
            result_n = to_inf ? {s2_q.sign, EXP_MAX, {MAN_W{1'b0}}}
                              : {s2_q.sign, EXP_MAX - 1'b1, {MAN_W{1'b1}}};
            flags_n  = 5'b00101;
        end else begin
            result_n = {s2_q.sign, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
            flags_n  = {4'b0000, inexact};
        end

        result_d    = result_q;
        flags_d     = flags_q;
        valid_out_d = valid_out_q;
        if (en) begin
            result_d    = result_n;
            flags_d     = flags_n;
            valid_out_d = s2_q.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            valid_out_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            valid_out_q <= valid_out_d;
        end
    end

`ifdef FP_ADDSUB_STICKY_FLAGS_EN
    logic [4:0] flags_acc_q, flags_acc_d;

    always_comb begin
        flags_acc_d = flags_acc_q;
        if (valid_out_q && bus.ready_in) flags_acc_d = flags_acc_q | flags_q;
        if (flags_clr) flags_acc_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) flags_acc_q <= '0;
        else     flags_acc_q <= flags_acc_d;
    end

    assign flags_acc = flags_acc_q;
`endif
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: directed binary32 vectors through a scoreboard queue,
// latency, backpressure stall and mid-flight reset scenarios.
module tb_fp_addsub_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [1:0]   rm;
        logic [W-1:0] res;
        logic [4:0]   flg;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_addsub_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

`ifdef FP_ADDSUB_STICKY_FLAGS_EN
    logic       flags_clr = 1'b0;
    logic [4:0] flags_acc;
`endif

    fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FP_ADDSUB_STICKY_FLAGS_EN
        ,
        .flags_clr (flags_clr),
        .flags_acc (flags_acc)
`endif
    );

    vec_t         vq[$];
    logic [W+4:0] exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           n_rx     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                input logic [1:0] rm, input logic [31:0] res, input logic [4:0] flg);
        vec_t v;
        v.a = a; v.b = b; v.sub = sub; v.rm = rm; v.res = res; v.flg = flg;
        return v;
    endfunction

    // Scoreboard: pop one expectation per consumed result
    initial begin
        logic [W+4:0] e;
        forever begin
            @(negedge clk);
            if (bus.valid_out && bus.ready_in) begin
                n_rx++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {63'd0, bus.valid_out}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_flags", {27'd0, bus.result, bus.flags}, {27'd0, e});
                end
            end
        end
    end

    task automatic send(input vec_t v, input bit push);
        int n;
        @(negedge clk);
        bus.op_a       = v.a;
        bus.op_b       = v.b;
        bus.op_sub     = v.sub;
        bus.round_mode = v.rm;
        bus.start      = 1'b1;
        n = 0;
        while (!bus.ready_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready_out) begin
            check("accept_ready", {63'd0, bus.ready_out}, 64'd1);
            bus.start = 1'b0;
            return;
        end
        if (push) exp_q.push_back({v.res, v.flg});
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_latency(input vec_t v);
        int lat;
        lat = 0;
        send(v, 1'b1);
        #1 bus.start = 1'b0;
        for (int i = 2; i <= 12 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid_out) lat = i;
        end
        check("latency", 64'(lat), 64'd3);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t v_lat;
        int   rx0;

        bus.op_a = '0; bus.op_b = '0; bus.op_sub = 1'b0; bus.round_mode = 2'b00;
        bus.start = 1'b0; bus.ready_in = 1'b1;

        v_lat = mk(32'h41A60000, 32'h40100000, 1'b0, 2'b00, 32'h41B80000, 5'b00000);
        vq.push_back(mk(32'h42293333, 32'h418828F6, 1'b1, 2'b00, 32'h41CA3D70, 5'b00000));
        vq.push_back(mk(32'h3F800000, 32'h33800000, 1'b0, 2'b00, 32'h3F800000, 5'b00001));
        vq.push_back(mk(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, 32'h7F800000, 5'b00101));
        vq.push_back(mk(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b01, 32'h7F7FFFFF, 5'b00101));
        vq.push_back(mk(32'h7F800000, 32'h7F800000, 1'b1, 2'b00, 32'h7FC00000, 5'b10000));
        vq.push_back(mk(32'h40A80000, 32'h40A80000, 1'b1, 2'b00, 32'h00000000, 5'b00000));
        vq.push_back(mk(32'h40A80000, 32'h40A80000, 1'b1, 2'b11, 32'h80000000, 5'b00000));
        vq.push_back(mk(32'h3F800000, 32'h33800000, 1'b0, 2'b10, 32'h3F800001, 5'b00001));
        vq.push_back(mk(32'hBF800000, 32'hB3800000, 1'b0, 2'b11, 32'hBF800001, 5'b00001));
        vq.push_back(mk(32'h3F800000, 32'h33C00000, 1'b0, 2'b00, 32'h3F800001, 5'b00001));
        vq.push_back(mk(32'h3FFFFFFF, 32'h33800000, 1'b0, 2'b00, 32'h40000000, 5'b00001));
        vq.push_back(mk(32'h3FFFFFFF, 32'h34000000, 1'b0, 2'b00, 32'h40000000, 5'b00000));
        vq.push_back(mk(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 2'b10, 32'hFF7FFFFF, 5'b00101));
        vq.push_back(mk(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 2'b11, 32'hFF800000, 5'b00101));
        vq.push_back(mk(32'h7FC00000, 32'h3F800000, 1'b0, 2'b00, 32'h7FC00000, 5'b00000));
        vq.push_back(mk(32'h7F800001, 32'h00000000, 1'b0, 2'b00, 32'h7FC00000, 5'b10000));
        vq.push_back(mk(32'h7F800000, 32'h3F800000, 1'b1, 2'b00, 32'h7F800000, 5'b00000));
        vq.push_back(mk(32'h00000001, 32'h3F800000, 1'b0, 2'b00, 32'h3F800000, 5'b00000));
        vq.push_back(mk(32'h00800000, 32'h00C00000, 1'b1, 2'b00, 32'h80000000, 5'b00011));
        vq.push_back(mk(32'h80000000, 32'h80000000, 1'b0, 2'b00, 32'h80000000, 5'b00000));
        vq.push_back(mk(32'h00000000, 32'h80000000, 1'b0, 2'b00, 32'h00000000, 5'b00000));
        vq.push_back(mk(32'h3F800000, 32'h40000000, 1'b1, 2'b00, 32'hBF800000, 5'b00000));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", {63'd0, bus.valid_out}, 64'd0);
        check("rst_result", {32'd0, bus.result}, 64'd0);
        check("rst_flags", {59'd0, bus.flags}, 64'd0);
        check("rst_ready_out", {63'd0, bus.ready_out}, 64'd1);
        rst = 1'b0;

        run_latency(v_lat);
        drain();

        // Back-to-back directed stream
        for (int i = 0; i < vq.size(); i++) send(vq[i], 1'b1);
        idle();
        drain();

        // Six ops with a five-cycle downstream stall mid-stream
        rx0 = n_rx;
        fork
            begin
                for (int i = 0; i < 6; i++) send(vq[i], 1'b1);
                idle();
            end
            begin
                repeat (4) @(posedge clk);
                #2 bus.ready_in = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_ready_out", {63'd0, bus.ready_out}, 64'd0);
                end
                @(posedge clk);
                #2 bus.ready_in = 1'b1;
            end
        join
        drain();
        check("stall_count", 64'(n_rx - rx0), 64'd6);

        // Reset with two ops in flight: they must vanish
        send(vq[0], 1'b0);
        send(vq[1], 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("rst_flush", {63'd0, bus.valid_out}, 64'd0);
        end
        run_latency(v_lat);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
